// File: rtl/ldpc_pkg.sv
// Shared definitions for the (15-bit, 10-check) LDPC code: sizes, controller
// states and the parity-check / flip-rule helper functions.
package ldpc_pkg;

   localparam int N_BITS   = 15;
   localparam int N_CHECKS = 10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // Bit 0 of the word is the MSB, so vectors are declared ascending.
   function automatic logic [0:N_CHECKS-1] ldpc_syndrome(input logic [0:N_BITS-1] w);
      logic [0:N_CHECKS-1] c;
      c[0] = w[0]  ^ w[4]  ^ w[5];
      c[1] = w[0]  ^ w[1]  ^ w[6];
      c[2] = w[1]  ^ w[2]  ^ w[7];
      c[3] = w[2]  ^ w[3]  ^ w[8];
      c[4] = w[3]  ^ w[4]  ^ w[9];
      c[5] = w[5]  ^ w[10] ^ w[14];
      c[6] = w[8]  ^ w[10] ^ w[11];
      c[7] = w[6]  ^ w[11] ^ w[12];
      c[8] = w[9]  ^ w[12] ^ w[13];
      c[9] = w[7]  ^ w[13] ^ w[14];
      return c;
   endfunction

   // A bit is flipped only when both checks it participates in are failing.
   function automatic logic [0:N_BITS-1] ldpc_flip_mask(input logic [0:N_CHECKS-1] c);
      logic [0:N_BITS-1] m;
      m[0]  = c[0] & c[1];
      m[1]  = c[1] & c[2];
      m[2]  = c[2] & c[3];
      m[3]  = c[3] & c[4];
      m[4]  = c[0] & c[4];
      m[5]  = c[0] & c[5];
      m[6]  = c[1] & c[7];
      m[7]  = c[2] & c[9];
      m[8]  = c[3] & c[6];
      m[9]  = c[4] & c[8];
      m[10] = c[5] & c[6];
      m[11] = c[6] & c[7];
      m[12] = c[7] & c[8];
      m[13] = c[8] & c[9];
      m[14] = c[5] & c[9];
      return m;
   endfunction

endpackage

// File: rtl/ldpc_bf_core.sv
// Combinational syndrome and flip-mask generation for one bit-flip iteration.
module ldpc_bf_core
   import ldpc_pkg::*;
(
   input  logic [0:N_BITS-1]   word,
   output logic [0:N_CHECKS-1] syndrome,
   output logic [0:N_BITS-1]   mask
);

   assign syndrome = ldpc_syndrome(word);
   assign mask     = ldpc_flip_mask(syndrome);

endmodule

// File: rtl/ldpc_bf_decoder_ctrl.sv
// Bit-flipping decoder controller: accepts a word, flips one iteration per
// clock until clean, stalled or out of iterations, then holds the result.
module ldpc_bf_decoder_ctrl
   import ldpc_pkg::*;
#(
   parameter int MAX_ITER = 8,
   parameter int ITER_W   = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [0:N_BITS-1]   in_word,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [0:N_BITS-1]   out_word,
   output logic                out_ok,
   output logic [ITER_W-1:0]   out_iter,
   output logic [0:N_CHECKS-1] syndrome,
   output logic                busy
);

   state_t            state;
   logic [0:N_BITS-1] work;
   logic [0:N_BITS-1] mask;
   logic [ITER_W-1:0] iter;

   ldpc_bf_core u_core (
      .word     (work),
      .syndrome (syndrome),
      .mask     (mask)
   );

   // Handshake flags depend on the state register only, never on inputs.
   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state == S_DECODE);
   assign out_word  = work;

   // NOTE: all state uses non-blocking assignments so every bit of the
   // register flips from the same syndrome snapshot taken before the edge.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= S_IDLE;
         work     <= '0;
         iter     <= '0;
         out_ok   <= 1'b0;
         out_iter <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  work  <= in_word;
                  iter  <= '0;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (syndrome == '0) begin
                  out_ok   <= 1'b1;
                  out_iter <= iter;
                  state    <= S_DONE;
               end else if (mask == '0 || iter == ITER_W'(MAX_ITER)) begin
                  out_ok   <= 1'b0;
                  out_iter <= iter;
                  state    <= S_DONE;
               end else begin
                  work <= work ^ mask;
                  iter <= iter + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/ldpc_bf_decoder_ctrl.md
# ldpc_bf_decoder_ctrl

Sequenced hard-decision bit-flipping decoder for the (15-bit, 10-check) LDPC code used in the `ldpc` area. It accepts one received word over a valid/ready handshake and iterates the parallel bit-flip rule, one iteration per clock, under an FSM. It stops on zero syndrome, on a stall (no flippable bit), or at an iteration limit, then presents the word with a status over an output valid/ready handshake. Upstream is the channel/slicer stage; downstream is the payload extractor.

## Interface
- `MAX_ITER`, 8: maximum flip iterations per word (1..15).
- `ITER_W`, 4: width of the iteration count; must hold `MAX_ITER`.
- `clk` in 1: single clock; all state changes on rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `in_valid` in 1: `in_word` is valid.
- `in_ready` out 1: block accepts a word (state IDLE).
- `in_word` in [0:14]: received hard bits; index 0 is the MSB.
- `out_valid` out 1: result valid; held until accepted.
- `out_ready` in 1: downstream accepts the result.
- `out_word` out [0:14]: decoded word (working register).
- `out_ok` out 1: 1 means the final syndrome is zero.
- `out_iter` out ITER_W: number of flip iterations applied.
- `syndrome` out [0:9]: checks computed on the working register; valid in every state.
- `busy` out 1: state is DECODE.

## Operation
- Checks (XOR), where b is the working register:
  - c0=b0^b4^b5
  - c1=b0^b1^b6
  - c2=b1^b2^b7
  - c3=b2^b3^b8
  - c4=b3^b4^b9
  - c5=b5^b10^b14
  - c6=b8^b10^b11
  - c7=b6^b11^b12
  - c8=b9^b12^b13
  - c9=b7^b13^b14
- Check pair per bit:
  - b0:c0,c1; b1:c1,c2; b2:c2,c3; b3:c3,c4; b4:c0,c4
  - b5:c0,c5; b6:c1,c7; b7:c2,c9; b8:c3,c6; b9:c4,c8
  - b10:c5,c6; b11:c6,c7; b12:c7,c8; b13:c8,c9; b14:c5,c9
- Flip mask bit i = AND of its two checks. All bits update in the same cycle from one syndrome snapshot.
- FSM states: IDLE, DECODE, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid&in_ready`: load `in_word` into the working register, clear the iteration counter, go to DECODE.
- DECODE, priority order each cycle:
  - Syndrome==0: go to DONE, ok=1.
  - Else flip mask==0 (stall): go to DONE, ok=0.
  - Else iter==`MAX_ITER`: go to DONE, ok=0.
  - Else: register ^= mask, iter += 1, stay in DECODE.
- DONE:
  - `out_valid`=1; `out_word`, `out_ok`, `out_iter` held stable.
  - On `out_valid&out_ready`: go to IDLE.
  - `in_valid` is ignored outside IDLE.
- `out_ok` and `out_iter` are registered on the DECODE→DONE transition.
- Reset (any state, including mid-decode or while `out_valid` is held): state IDLE, working register 0, iter 0, `out_ok` 0, `out_valid` 0. The in-flight word is discarded with no output.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `busy`=0, `out_ok`=0, `out_iter`=0.
  - `out_word`=0, `syndrome`=0.
- Accept at edge T: DECODE during T+1. With k flip iterations, `out_valid` rises after edge T+k+1, so latency is k+2 cycles from accept to `out_valid`.
- Clean word: `out_valid` two cycles after accept, `out_iter`=0.
- From DONE, the output handshake at edge T returns to IDLE; `in_ready`=1 from T+1. There is no same-cycle turnaround, so peak throughput is one word per k+3 cycles.
- `in_ready`, `out_valid` and `busy` decode only from the state register; there is no combinational path from inputs to them.

## Structure
- Package `ldpc_pkg`:
  - Constants `N_BITS`=15 and `N_CHECKS`=10.
  - State enum.
  - Functions `ldpc_syndrome(word)` and `ldpc_flip_mask(syn)`, shared with existing datapath checks.
- Sub-module `ldpc_bf_core`: combinational syndrome and flip-mask generation, with ports word→syndrome,mask.
- The controller holds the FSM, working register, iteration counter and handshakes.

## Test plan
- Reset release, `in_word`=15'b000000000000000: `in_ready`=1, and `out_valid`=1 two cycles after accept with `out_ok`=1, `out_iter`=0, word unchanged.
- `in_word`=15'b100000000000000 (b0 error; c0,c1 fail): one flip, then `out_word`=0, `out_ok`=1, `out_iter`=1, latency 3.
- `in_word`=15'b111110000000000 (valid nonzero codeword): `out_ok`=1, `out_iter`=0, word unchanged.
- `in_word`=15'b110000000000000 (c0,c2 fail, no bit has both checks failing): stall, `out_ok`=0, `out_iter`=0, `out_word` equals input.
- Backpressure: hold `out_ready`=0 for 5 cycles while pulsing `in_valid`. `out_valid` and outputs stay stable, `in_ready`=0 and no new load; release gives a single transfer, then `in_ready`=1 on the next cycle.
- Drive `resetn`=0 during DECODE (`MAX_ITER`=1, two-error input): next cycle IDLE, all outputs at reset values, no `out_valid` pulse.
